// File: rtl/input_debounce_if.sv
// Raw pad inputs and debounced outputs of the switch/button front end.
// The board/driver side uses master; the debouncer uses slave.
interface input_debounce_if #(
    parameter int unsigned SW_W  = 8,
    parameter int unsigned BTN_W = 5
);
    logic [SW_W-1:0]  sw_raw;
    logic [BTN_W-1:0] btn_raw;
    logic [SW_W-1:0]  sw_db;
    logic [BTN_W-1:0] btn_db;
    logic [BTN_W-1:0] btn_press;

    modport master (
        output sw_raw,
        output btn_raw,
        input  sw_db,
        input  btn_db,
        input  btn_press
    );

    modport slave (
        input  sw_raw,
        input  btn_raw,
        output sw_db,
        output btn_db,
        output btn_press
    );
endinterface

// File: rtl/input_debounce.sv
// Switch/button front end: 2-flop synchronisers, tick-sampled per-bit debounce,
// and one-cycle press pulses on debounced button rises.
module input_debounce #(
    parameter int unsigned SW_W         = 8,
    parameter int unsigned BTN_W        = 5,
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned STABLE_TICKS = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input_debounce_if.slave bus
);
    localparam int unsigned ALL_W = SW_W + BTN_W;
    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned STB_W = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_TICKS - 1);

    generate
        if (TICK_DIV < 1 || STABLE_TICKS < 1) begin : g_bad_params
            $error("input_debounce: TICK_DIV and STABLE_TICKS must be >= 1");
        end
    endgenerate

    // Switches occupy the low bits, buttons the high bits of every per-bit vector.
    logic [ALL_W-1:0] raw_c;
    logic [ALL_W-1:0] sync1_q;
    logic [ALL_W-1:0] sync2_q;

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             tick_c;

    logic [ALL_W-1:0] db_q;
    logic [ALL_W-1:0] db_d;
    logic [STB_W-1:0] stb_q [ALL_W];
    logic [STB_W-1:0] stb_d [ALL_W];

    logic [BTN_W-1:0] press_q;
    logic [BTN_W-1:0] press_d;

    assign raw_c = {bus.btn_raw, bus.sw_raw};

    // Two-flop synchroniser; only the second stage feeds logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_c;
            sync2_q <= sync1_q;
        end
    end

    // Sample-tick prescaler.
    assign tick_c = (div_q == DIV_LAST);

    always_comb begin
        div_d = div_q + DIV_W'(1);
        if (tick_c) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // A tick that sees the accepted level again discards all progress toward a change.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < int'(ALL_W); i++) begin
            stb_d[i] = stb_q[i];
            if (tick_c) begin
                if (sync2_q[i] == db_q[i]) begin
                    stb_d[i] = '0;
                end else if (stb_q[i] == STB_LAST) begin
                    db_d[i]  = sync2_q[i];
                    stb_d[i] = '0;
                end else begin
                    stb_d[i] = stb_q[i] + STB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q <= '0;
            for (int i = 0; i < int'(ALL_W); i++) begin
                stb_q[i] <= '0;
            end
        end else begin
            db_q <= db_d;
            for (int i = 0; i < int'(ALL_W); i++) begin
                stb_q[i] <= stb_d[i];
            end
        end
    end

    // Registering next & ~current lines the pulse up with the first cycle btn_db is high.
    assign press_d = db_d[ALL_W-1:SW_W] & ~db_q[ALL_W-1:SW_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_q <= '0;
        end else begin
            press_q <= press_d;
        end
    end

    assign bus.sw_db     = db_q[SW_W-1:0];
    assign bus.btn_db    = db_q[ALL_W-1:SW_W];
    assign bus.btn_press = press_q;

endmodule

// File: tb/tb_input_debounce.sv
// Scoreboard bench for input_debounce: fast-tick instance (dut1) for exact latencies,
// divided-tick instance (dut2) for the latency window.
module tb_input_debounce;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    typedef struct {
        int          cyc;
        int          dut;
        logic [7:0]  sw;
        logic [4:0]  btn;
        logic [4:0]  press;
        string       tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    input_debounce_if #(.SW_W(8), .BTN_W(5)) if1 ();
    input_debounce_if #(.SW_W(8), .BTN_W(5)) if2 ();

    input_debounce #(.SW_W(8), .BTN_W(5), .TICK_DIV(1), .STABLE_TICKS(3)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    input_debounce #(.SW_W(8), .BTN_W(5), .TICK_DIV(4), .STABLE_TICKS(3)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_span(input int dut, input int lo, input int hi, input logic [7:0] sw,
                            input logic [4:0] btn, input logic [4:0] pr, input string tag);
        for (int k = lo; k <= hi; k++) begin
            sb.push_back('{cyc + k, dut, sw, btn, pr, tag});
        end
    endtask

    // Pop every expectation due this cycle and compare against the matching instance.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                mon_e = sb[i];
                if (mon_e.dut == 1) begin
                    check({mon_e.tag, "_sw"},    32'(if1.sw_db),     32'(mon_e.sw));
                    check({mon_e.tag, "_btn"},   32'(if1.btn_db),    32'(mon_e.btn));
                    check({mon_e.tag, "_press"}, 32'(if1.btn_press), 32'(mon_e.press));
                end else begin
                    check({mon_e.tag, "_sw"},    32'(if2.sw_db),     32'(mon_e.sw));
                    check({mon_e.tag, "_btn"},   32'(if2.btn_db),    32'(mon_e.btn));
                    check({mon_e.tag, "_press"}, 32'(if2.btn_press), 32'(mon_e.press));
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        int lat;
        rst_n = 1'b1;
        if1.sw_raw = '0; if1.btn_raw = '0;
        if2.sw_raw = '0; if2.btn_raw = '0;
        #2 rst_n = 1'b0;
        step();

        // Raw activity under reset never reaches the outputs.
        repeat (6) begin
            if1.sw_raw  = 8'($urandom);
            if1.btn_raw = 5'($urandom);
            if2.sw_raw  = 8'($urandom);
            if2.btn_raw = 5'($urandom);
            exp_span(1, 0, 0, 8'h00, 5'h00, 5'h00, "t1_rst");
            exp_span(2, 0, 0, 8'h00, 5'h00, 5'h00, "t1_rst_d2");
            step();
        end
        if1.sw_raw = '0; if1.btn_raw = '0;
        if2.sw_raw = '0; if2.btn_raw = '0;
        rst_n = 1'b1;
        exp_span(1, 0, 4, 8'h00, 5'h00, 5'h00, "t1_post");
        repeat (6) step();

        // Single switch bit: accepted exactly 5 edges later.
        if1.sw_raw = 8'h04;
        exp_span(1, 0, 4, 8'h00, 5'h00, 5'h00, "t2_wait");
        exp_span(1, 5, 7, 8'h04, 5'h00, 5'h00, "t2_rise");
        repeat (8) step();

        // Bouncing button, then held.
        for (int b = 0; b < 4; b++) begin
            if1.btn_raw = (b % 2 == 0) ? 5'h01 : 5'h00;
            exp_span(1, 0, 0, 8'h04, 5'h00, 5'h00, "t3_bounce");
            step();
        end
        if1.btn_raw = 5'h01;
        exp_span(1, 0, 4, 8'h04, 5'h00, 5'h00, "t3_settle");
        exp_span(1, 5, 5, 8'h04, 5'h01, 5'h01, "t3_press");
        exp_span(1, 6, 7, 8'h04, 5'h01, 5'h00, "t3_hold");
        repeat (8) step();

        // Two-cycle glitch on btn[2] is rejected.
        if1.btn_raw = 5'h05;
        exp_span(1, 0, 1, 8'h04, 5'h01, 5'h00, "t4_glitch");
        step(); step();
        if1.btn_raw = 5'h01;
        exp_span(1, 0, 7, 8'h04, 5'h01, 5'h00, "t4_glitch_after");
        repeat (8) step();

        // Release: level falls after 5 edges, no pulse.
        if1.btn_raw = 5'h00;
        exp_span(1, 0, 4, 8'h04, 5'h01, 5'h00, "t4_rel_wait");
        exp_span(1, 5, 7, 8'h04, 5'h00, 5'h00, "t4_released");
        repeat (8) step();

        // Several switches and buttons changing in the same cycle.
        if1.sw_raw  = 8'h5B;
        if1.btn_raw = 5'h12;
        exp_span(1, 0, 4, 8'h04, 5'h00, 5'h00, "t2b_wait");
        exp_span(1, 5, 5, 8'h5B, 5'h12, 5'h12, "t2b_press");
        exp_span(1, 6, 7, 8'h5B, 5'h12, 5'h00, "t2b_hold");
        repeat (8) step();

        // Divided tick: acceptance falls inside the 11..14 edge window.
        if2.sw_raw = 8'h80;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (lat == 0 && if2.sw_db[7] === 1'b1) lat = k;
        end
        check("t5_lat_ge_11", 32'(lat >= 11), 32'd1);
        check("t5_lat_le_14", 32'(lat <= 14 && lat != 0), 32'd1);
        check("t5_other_sw", 32'(if2.sw_db & 8'h7F), 32'd0);
        check("t5_btn_press", 32'(if2.btn_press), 32'd0);

        // Reset mid-count, then all buttons accepted together with one pulse.
        if1.btn_raw = 5'h1F;
        exp_span(1, 0, 2, 8'h5B, 5'h12, 5'h00, "t6_pre");
        repeat (3) step();
        rst_n = 1'b0;
        exp_span(1, 0, 2, 8'h00, 5'h00, 5'h00, "t6_in_rst");
        exp_span(2, 0, 0, 8'h00, 5'h00, 5'h00, "t6_in_rst_d2");
        repeat (2) step();
        rst_n = 1'b1;
        exp_span(1, 1, 4, 8'h00, 5'h00, 5'h00, "t6_post_wait");
        exp_span(1, 5, 5, 8'h5B, 5'h1F, 5'h1F, "t6_press");
        exp_span(1, 6, 8, 8'h5B, 5'h1F, 5'h00, "t6_hold");
        repeat (9) step();

        for (int w = 0; w < 50 && sb.size() != 0; w++) step();
        check("drain_pending", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
